// File: rtl/nw_pkg.sv
// ============================================================================
// Module   : nw_pkg
// Brief    : Shared score width, sequencer state encoding and RAM address map
//            for the NW matrix-fill datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nw_pkg;

    localparam int SCORE_W = 9;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_DIAG  = 3'd1,
        RD_UP    = 3'd2,
        RD_LEFT  = 3'd3,
        CAP_LEFT = 3'd4,
        PRESENT  = 3'd5,
        WAIT_RES = 3'd6,
        WRITE    = 3'd7
    } state_t;

    // Row-major placement of the (n+1)x(n+1) score matrix in the RAM
    function automatic int unsigned cell_addr(input int unsigned i,
                                              input int unsigned j,
                                              input int unsigned n);
        return i * (n + 1) + j;
    endfunction

endpackage

`default_nettype wire

// File: rtl/score_cell_sequencer_if.sv
// ============================================================================
// Module   : score_cell_sequencer_if
// Brief    : Score RAM port and cell compute-engine handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface score_cell_sequencer_if #(
    parameter int N       = 8,
    parameter int SCORE_W = nw_pkg::SCORE_W,
    parameter int IDX_W   = $clog2(N + 1),
    parameter int ADDR_W  = $clog2((N + 1) * (N + 1))
);
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_rd_en;
    logic               ram_we;
    logic [SCORE_W-1:0] ram_wdata;
    logic [SCORE_W-1:0] ram_rdata;
    logic [SCORE_W-1:0] diag;
    logic [SCORE_W-1:0] up;
    logic [SCORE_W-1:0] left;
    logic [IDX_W-1:0]   cell_i;
    logic [IDX_W-1:0]   cell_j;
    logic               cell_valid;
    logic               cell_ready;
    logic               res_valid;
    logic [SCORE_W-1:0] res_score;

    modport master (
        output ram_addr, ram_rd_en, ram_we, ram_wdata,
        input  ram_rdata,
        output diag, up, left, cell_i, cell_j, cell_valid,
        input  cell_ready, res_valid, res_score
    );

    modport slave (
        input  ram_addr, ram_rd_en, ram_we, ram_wdata,
        output ram_rdata,
        input  diag, up, left, cell_i, cell_j, cell_valid,
        output cell_ready, res_valid, res_score
    );
endinterface

`default_nettype wire

// File: rtl/cell_index_counter.sv
// ============================================================================
// Module   : cell_index_counter
// Brief    : Row-major (i,j) walker over the matrix interior with the
//            neighbour and self RAM addresses of the current cell.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cell_index_counter #(
    parameter int N      = 8,
    parameter int IDX_W  = $clog2(N + 1),
    parameter int ADDR_W = $clog2((N + 1) * (N + 1))
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              clear,
    input  wire logic              advance,
    output logic [IDX_W-1:0]       cell_i,
    output logic [IDX_W-1:0]       cell_j,
    output logic                   last_cell,
    output logic [ADDR_W-1:0]      addr_diag,
    output logic [ADDR_W-1:0]      addr_up,
    output logic [ADDR_W-1:0]      addr_left,
    output logic [ADDR_W-1:0]      addr_self
);
    import nw_pkg::*;

    localparam logic [IDX_W-1:0] C_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] C_N   = IDX_W'(N);

    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i <= C_ONE;
            r_j <= C_ONE;
        end else if (clear || (advance && last_cell)) begin
            r_i <= C_ONE;
            r_j <= C_ONE;
        end else if (advance) begin
            if (r_j < C_N) begin
                r_j <= r_j + C_ONE;
            end else begin
                r_i <= r_i + C_ONE;
                r_j <= C_ONE;
            end
        end
    end

    assign cell_i    = r_i;
    assign cell_j    = r_j;
    assign last_cell = (r_i == C_N) && (r_j == C_N);

    // i and j never drop below 1, so the minus-one neighbours stay in range
    assign addr_diag = ADDR_W'(cell_addr(32'(r_i) - 32'd1, 32'(r_j) - 32'd1, N));
    assign addr_up   = ADDR_W'(cell_addr(32'(r_i) - 32'd1, 32'(r_j), N));
    assign addr_left = ADDR_W'(cell_addr(32'(r_i), 32'(r_j) - 32'd1, N));
    assign addr_self = ADDR_W'(cell_addr(32'(r_i), 32'(r_j), N));

endmodule

`default_nettype wire

// File: rtl/score_cell_sequencer.sv
// ============================================================================
// Module   : score_cell_sequencer
// Brief    : Drives the single-port score RAM through read-diag/up/left,
//            hands neighbours to the cell engine and writes the result back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_cell_sequencer #(
    parameter int N       = 8,
    parameter int SCORE_W = nw_pkg::SCORE_W,
    parameter int IDX_W   = $clog2(N + 1),
    parameter int ADDR_W  = $clog2((N + 1) * (N + 1))
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 start,
    score_cell_sequencer_if.master    bus,
    output logic                      busy,
    output logic                      done
);
    import nw_pkg::*;

    state_t             r_state;
    state_t             w_next;
    logic [SCORE_W-1:0] r_diag;
    logic [SCORE_W-1:0] r_up;
    logic [SCORE_W-1:0] r_left;
    logic [SCORE_W-1:0] r_wdata;
    logic               r_done;

    logic               w_clear;
    logic               w_advance;
    logic               w_last;
    logic [IDX_W-1:0]   w_cell_i;
    logic [IDX_W-1:0]   w_cell_j;
    logic [ADDR_W-1:0]  w_addr_diag;
    logic [ADDR_W-1:0]  w_addr_up;
    logic [ADDR_W-1:0]  w_addr_left;
    logic [ADDR_W-1:0]  w_addr_self;

    cell_index_counter #(
        .N      (N),
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W)
    ) u_index (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .advance   (w_advance),
        .cell_i    (w_cell_i),
        .cell_j    (w_cell_j),
        .last_cell (w_last),
        .addr_diag (w_addr_diag),
        .addr_up   (w_addr_up),
        .addr_left (w_addr_left),
        .addr_self (w_addr_self)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_clear       = 1'b0;
        w_advance     = 1'b0;
        bus.ram_addr  = '0;
        bus.ram_rd_en = 1'b0;
        bus.ram_we    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next  = RD_DIAG;
                    w_clear = 1'b1;
                end
            end
            RD_DIAG: begin
                bus.ram_rd_en = 1'b1;
                bus.ram_addr  = w_addr_diag;
                w_next        = RD_UP;
            end
            RD_UP: begin
                bus.ram_rd_en = 1'b1;
                bus.ram_addr  = w_addr_up;
                w_next        = RD_LEFT;
            end
            RD_LEFT: begin
                bus.ram_rd_en = 1'b1;
                bus.ram_addr  = w_addr_left;
                w_next        = CAP_LEFT;
            end
            CAP_LEFT: w_next = PRESENT;
            PRESENT: begin
                if (bus.cell_ready) begin
                    w_next = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (bus.res_valid) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                bus.ram_we   = 1'b1;
                bus.ram_addr = w_addr_self;
                w_advance    = 1'b1;
                w_next       = w_last ? IDLE : RD_DIAG;
            end
            default: w_next = IDLE;
        endcase
    end

    // Read data lags the strobe by one cycle, so each capture sits one state late
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diag  <= '0;
            r_up    <= '0;
            r_left  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == WRITE) && w_last;
            case (r_state)
                RD_UP:    r_diag <= bus.ram_rdata;
                RD_LEFT:  r_up   <= bus.ram_rdata;
                CAP_LEFT: r_left <= bus.ram_rdata;
                WAIT_RES: begin
                    if (bus.res_valid) begin
                        r_wdata <= bus.res_score;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_wdata  = r_wdata;
    assign bus.diag       = r_diag;
    assign bus.up         = r_up;
    assign bus.left       = r_left;
    assign bus.cell_i     = w_cell_i;
    assign bus.cell_j     = w_cell_j;
    assign bus.cell_valid = (r_state == PRESENT);
    assign busy           = (r_state != IDLE);
    assign done           = r_done;

endmodule

`default_nettype wire

// File: tb/tb_score_cell_sequencer.sv
// ============================================================================
// Module   : tb_score_cell_sequencer
// Brief    : Randomized bench for score_cell_sequencer with a RAM model,
//            a cell engine and a whole-matrix reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_cell_sequencer;

    localparam int N   = 2;
    localparam int SW  = 9;
    localparam int IW  = $clog2(N + 1);
    localparam int AW  = $clog2((N + 1) * (N + 1));
    localparam int NUM = (N + 1) * (N + 1);

    typedef logic [3*SW+2*IW-1:0] pres_t;
    typedef logic [AW+SW-1:0]     wr_t;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;

    score_cell_sequencer_if #(.N(N), .SCORE_W(SW)) bus ();

    score_cell_sequencer #(.N(N), .SCORE_W(SW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus.master),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Engine: result depends on all three neighbours so a wrong read shows up
    function automatic logic [SW-1:0] engine_score(input logic [SW-1:0] d, input logic [SW-1:0] u,
                                                   input logic [SW-1:0] l, input logic [IW-1:0] i,
                                                   input logic [IW-1:0] j);
        return SW'(10 * int'(i) + int'(j) + int'(d) - int'(u) + 3 * int'(l));
    endfunction

    logic [SW-1:0] ram [0:NUM-1];
    logic [SW-1:0] exp_m [0:N][0:N];

    int  eng_rmode = 0;
    int  eng_dly   = 0;
    bit  eng_spur  = 0;

    // RAM model: sample the port mid-cycle, apply just after the edge
    initial begin : p_ram
        logic          m_we, m_rd;
        logic [AW-1:0] m_a;
        logic [SW-1:0] m_d;
        bus.ram_rdata = '0;
        forever begin
            @(negedge clk);
            m_we = bus.ram_we;
            m_rd = bus.ram_rd_en;
            m_a  = bus.ram_addr;
            m_d  = bus.ram_wdata;
            @(posedge clk);
            #1;
            if (m_we) ram[m_a] = m_d;
            if (m_rd) bus.ram_rdata = ram[m_a];
        end
    end

    initial begin : p_engine
        bit            pend;
        bit            rdy;
        int            cnt;
        int            hold;
        logic [SW-1:0] sc;
        pend = 0; cnt = 0; hold = 0; sc = '0;
        bus.cell_ready = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_score  = '0;
        forever begin
            @(negedge clk);
            if (rst || (pend && bus.res_valid)) pend = 0;
            if (bus.cell_valid && bus.cell_ready) begin
                pend = 1;
                cnt  = (eng_dly < 0) ? $urandom_range(0, 3) : eng_dly;
                sc   = engine_score(bus.diag, bus.up, bus.left, bus.cell_i, bus.cell_j);
            end
            @(posedge clk);
            #1;
            if (rst) pend = 0;
            rdy = 1'b1;
            if (bus.cell_valid) begin
                if (eng_rmode == 1)      rdy = ($urandom_range(0, 2) != 0);
                else if (eng_rmode == 2) rdy = (hold >= 5);
                if (!rdy) hold++;
            end else begin
                hold = 0;
            end
            bus.cell_ready = rdy;
            bus.res_valid  = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    bus.res_valid = 1'b1;
                    bus.res_score = sc;
                end else begin
                    cnt--;
                end
            end else if (eng_spur && bus.cell_valid && $urandom_range(0, 1) == 1) begin
                bus.res_valid = 1'b1;
                bus.res_score = SW'($urandom);
            end
        end
    end

    logic [AW-1:0] rd_q[$];
    wr_t           wr_q[$];
    pres_t         pres_q[$];
    logic [AW-1:0] exp_rd[$];
    wr_t           exp_wr[$];
    pres_t         exp_pres[$];
    int            done_cnt, excl_err, wait_err, stall_err, stall_cycles;
    bit            in_wait, prev_stall;
    pres_t         prev_vals;

    always @(negedge clk) begin
        if (bus.ram_rd_en && bus.ram_we) excl_err++;
        if (done) done_cnt++;
        if (bus.ram_rd_en) begin
            rd_q.push_back(bus.ram_addr);
            if (in_wait) wait_err++;
        end
        if (bus.ram_we) begin
            wr_q.push_back({bus.ram_addr, bus.ram_wdata});
            if (!in_wait) wait_err++;
            in_wait = 0;
        end
        if (bus.cell_valid && (bus.ram_rd_en || bus.ram_we)) stall_err++;
        if (prev_stall && (!bus.cell_valid ||
            prev_vals != {bus.diag, bus.up, bus.left, bus.cell_i, bus.cell_j})) stall_err++;
        prev_stall = bus.cell_valid && !bus.cell_ready;
        prev_vals  = {bus.diag, bus.up, bus.left, bus.cell_i, bus.cell_j};
        if (prev_stall) stall_cycles++;
        if (bus.cell_valid && bus.cell_ready) begin
            pres_q.push_back({bus.diag, bus.up, bus.left, bus.cell_i, bus.cell_j});
            in_wait = 1;
        end
    end

    // Border row/column, garbage interior, then the whole expected fill
    task automatic prep_fill(input bit std_init);
        for (int k = 0; k < NUM; k++) ram[k] = SW'($urandom);
        if (std_init) begin
            for (int k = 0; k <= N; k++) begin
                ram[k]         = SW'(-k);
                ram[k * (N+1)] = SW'(-k);
            end
        end
        for (int k = 0; k <= N; k++) begin
            exp_m[0][k] = ram[k];
            exp_m[k][0] = ram[k * (N+1)];
        end
        exp_rd.delete(); exp_wr.delete(); exp_pres.delete();
        for (int i = 1; i <= N; i++) begin
            for (int j = 1; j <= N; j++) begin
                exp_m[i][j] = engine_score(exp_m[i-1][j-1], exp_m[i-1][j], exp_m[i][j-1], IW'(i), IW'(j));
                exp_rd.push_back(AW'((i-1) * (N+1) + j - 1));
                exp_rd.push_back(AW'((i-1) * (N+1) + j));
                exp_rd.push_back(AW'(i * (N+1) + j - 1));
                exp_pres.push_back({exp_m[i-1][j-1], exp_m[i-1][j], exp_m[i][j-1], IW'(i), IW'(j)});
                exp_wr.push_back({AW'(i * (N+1) + j), exp_m[i][j]});
            end
        end
        rd_q.delete(); wr_q.delete(); pres_q.delete();
        done_cnt = 0; excl_err = 0; wait_err = 0; stall_err = 0; stall_cycles = 0;
        in_wait = 0; prev_stall = 0;
    endtask

    task automatic pulse_start(output int c0);
        @(posedge clk);
        #1;
        start = 1'b1;
        c0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_addr"},  64'(bus.ram_addr),   0);
        check_eq({pfx, "_rd_en"}, 64'(bus.ram_rd_en),  0);
        check_eq({pfx, "_we"},    64'(bus.ram_we),     0);
        check_eq({pfx, "_wdata"}, 64'(bus.ram_wdata),  0);
        check_eq({pfx, "_diag"},  64'(bus.diag),       0);
        check_eq({pfx, "_up"},    64'(bus.up),         0);
        check_eq({pfx, "_left"},  64'(bus.left),       0);
        check_eq({pfx, "_valid"}, 64'(bus.cell_valid), 0);
        check_eq({pfx, "_busy"},  64'(busy),           0);
        check_eq({pfx, "_done"},  64'(done),           0);
        check_eq({pfx, "_i"},     64'(bus.cell_i),     1);
        check_eq({pfx, "_j"},     64'(bus.cell_j),     1);
    endtask

    task automatic compare_results(input string tag, input bit chk_stall);
        check_eq({tag, "_rd_count"}, rd_q.size(), exp_rd.size());
        for (int k = 0; k < rd_q.size() && k < exp_rd.size(); k++)
            check_eq($sformatf("%s_rd%0d", tag, k), 64'(rd_q[k]), 64'(exp_rd[k]));
        check_eq({tag, "_pres_count"}, pres_q.size(), exp_pres.size());
        for (int k = 0; k < pres_q.size() && k < exp_pres.size(); k++)
            check_eq($sformatf("%s_pres%0d", tag, k), 64'(pres_q[k]), 64'(exp_pres[k]));
        check_eq({tag, "_wr_count"}, wr_q.size(), exp_wr.size());
        for (int k = 0; k < wr_q.size() && k < exp_wr.size(); k++)
            check_eq($sformatf("%s_wr%0d", tag, k), 64'(wr_q[k]), 64'(exp_wr[k]));
        for (int i = 1; i <= N; i++)
            for (int j = 1; j <= N; j++)
                check_eq($sformatf("%s_mem%0d%0d", tag, i, j), 64'(ram[i*(N+1)+j]), 64'(exp_m[i][j]));
        check_eq({tag, "_done_pulses"}, done_cnt, 1);
        check_eq({tag, "_rd_we_overlap"}, excl_err, 0);
        check_eq({tag, "_wait_phase"}, wait_err, 0);
        check_eq({tag, "_stall_hold"}, stall_err, 0);
        if (chk_stall) check_eq({tag, "_stall_cycles"}, stall_cycles, 5 * N * N);
    endtask

    task automatic run_fill(input int rmode, input int dly, input bit spur, input bit std_init,
                            input string tag);
        int c0;
        int done_at;
        bit got;
        eng_rmode = rmode;
        eng_dly   = dly;
        eng_spur  = spur;
        prep_fill(std_init);
        pulse_start(c0);
        got     = 0;
        done_at = 0;
        for (int k = 0; k < 4000 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got     = 1;
                done_at = cyc;
                check_eq({tag, "_busy_at_done"}, 64'(busy), 0);
            end else begin
                @(posedge clk);
                #1;
                start = spur && busy && ($urandom_range(0, 3) == 0);
            end
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, 64'(got), 1);
        if (rmode != 1 && dly >= 0)
            check_eq({tag, "_done_latency"}, done_at - c0, 1 + N * N * (7 + dly + (rmode == 2 ? 5 : 0)));
        repeat (3) @(negedge clk);
        compare_results(tag, rmode == 2);
    endtask

    task automatic reset_mid_fill();
        int c0;
        bit found;
        eng_rmode = 0;
        eng_dly   = 4;
        eng_spur  = 0;
        prep_fill(1'b1);
        pulse_start(c0);
        found = 0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk);
            if (bus.cell_valid && bus.cell_ready && bus.cell_i == IW'(2) && bus.cell_j == IW'(1))
                found = 1;
        end
        check_eq("rstmid_reached", 64'(found), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rstmid");
        @(negedge clk);
        check_reset_outputs("rstmid_hold");
        @(posedge clk);
        #2;
        rst = 1'b0;
        check_eq("rstmid_writes", wr_q.size(), 2);
        check_eq("rstmid_done", done_cnt, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;

        run_fill(0, 0, 1'b0, 1'b1, "basic");
        run_fill(2, 0, 1'b0, 1'b0, "backpress");
        run_fill(0, 4, 1'b0, 1'b0, "delayres");
        run_fill(0, 0, 1'b1, 1'b1, "ignored");
        reset_mid_fill();
        run_fill(0, 0, 1'b0, 1'b1, "restart");
        for (int r = 0; r < 4; r++)
            run_fill(1, -1, 1'b1, 1'b0, $sformatf("rand%0d", r));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
